// File: rtl/access_guard_ctrl.sv
// Access-policy and door-actuation controller: walks an EEPROM allowlist on each
// authentication, drives per-door unlock timers and enforces a failed-attempt lockout.
module access_guard_ctrl #(
    parameter int         NUM_DOORS      = 2,
    parameter int         ID_BYTES       = 4,
    parameter int         NUM_ENTRIES    = 8,
    parameter logic [6:0] BASE_ADDR      = 7'h20,
    parameter int         UNLOCK_CYCLES  = 500000000,
    parameter int         MAX_FAILS      = 3,
    parameter int         LOCKOUT_CYCLES = 1000000000,
    localparam int        DSEL_W         = (NUM_DOORS > 1) ? $clog2(NUM_DOORS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  auth_success_i,
    input  logic                  auth_failed_i,
    input  logic [8*ID_BYTES-1:0] card_id_i,
    input  logic [DSEL_W-1:0]     door_sel_i,
    output logic                  ee_req_valid_o,
    input  logic                  ee_req_ready_i,
    output logic [6:0]            ee_req_addr_o,
    input  logic                  ee_rsp_valid_i,
    input  logic [7:0]            ee_rsp_data_i,
    output logic [NUM_DOORS-1:0]  door_unlock_o,
    output logic                  status_granted_o,
    output logic                  status_denied_o,
    output logic                  lockout_o,
    output logic                  busy_o
);

    localparam int EW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int UW = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES + 1) : 1;
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
    localparam int FW = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1;
    localparam logic [6:0] STRIDE = 7'(ID_BYTES + 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, GRANT, DENY} state_e;

    state_e                state_q;
    logic [EW-1:0]         entry_q;
    logic [3:0]            byte_q;
    logic [6:0]            addr_q;
    logic [8*ID_BYTES-1:0] card_q;
    logic [DSEL_W-1:0]     sel_q;
    logic [FW-1:0]         fail_q;
    logic [LW-1:0]         lock_timer_q;
    logic                  lockout_q;
    logic                  req_valid_q;
    logic                  granted_q;
    logic                  denied_q;
    logic [UW-1:0]         door_timer_q [NUM_DOORS];
    logic [NUM_DOORS-1:0]  unlock_q;

    logic [7:0] id_byte;
    logic       mask_ok;
    logic       byte_ok;
    logic       rsp_fire;
    logic       is_last_byte;
    logic       is_last_entry;
    logic       idle_deny;
    logic       grant_fire;
    logic       deny_fire;
    logic       lock_trip;
    logic [6:0] next_entry_addr;

    // Expected ID byte for the current byte index and the mask bit of the requested door.
    always_comb begin
        id_byte = 8'h00;
        for (int k = 1; k <= ID_BYTES; k++) begin
            if (byte_q == 4'(k)) id_byte = card_q[8*(ID_BYTES-k) +: 8];
        end
        mask_ok = 1'b0;
        for (int d = 0; d < NUM_DOORS; d++) begin
            if (sel_q == DSEL_W'(d)) mask_ok = ee_rsp_data_i[d];
        end
    end

    assign rsp_fire        = (state_q == WAIT) && ee_rsp_valid_i;
    assign is_last_byte    = (byte_q == 4'(ID_BYTES));
    assign is_last_entry   = (entry_q == EW'(NUM_ENTRIES - 1));
    assign byte_ok         = (byte_q == 4'd0) ? mask_ok : (ee_rsp_data_i == id_byte);
    assign idle_deny       = (state_q == IDLE) && (auth_failed_i || (auth_success_i && lockout_q));
    assign grant_fire      = rsp_fire && byte_ok && is_last_byte;
    assign deny_fire       = idle_deny || (rsp_fire && !byte_ok && is_last_entry);
    assign lock_trip       = deny_fire && !lockout_q && (fail_q == FW'(MAX_FAILS - 1));
    assign next_entry_addr = BASE_ADDR + (7'(entry_q) + 7'd1) * STRIDE;

    // Status pulses, fail counter and lockout are updated on the deciding edge so they
    // line up with the transition into GRANT/DENY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            entry_q      <= '0;
            byte_q       <= '0;
            addr_q       <= '0;
            card_q       <= '0;
            sel_q        <= '0;
            fail_q       <= '0;
            lock_timer_q <= '0;
            lockout_q    <= 1'b0;
            req_valid_q  <= 1'b0;
            granted_q    <= 1'b0;
            denied_q     <= 1'b0;
        end else begin
            granted_q <= grant_fire;
            denied_q  <= deny_fire;
            case (state_q)
                IDLE: begin
                    if (idle_deny) begin
                        state_q <= DENY;
                    end else if (auth_success_i) begin
                        card_q      <= card_id_i;
                        sel_q       <= door_sel_i;
                        entry_q     <= '0;
                        byte_q      <= '0;
                        addr_q      <= BASE_ADDR;
                        req_valid_q <= 1'b1;
                        state_q     <= FETCH;
                    end
                end
                FETCH: begin
                    if (ee_req_ready_i) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (ee_rsp_valid_i) begin
                        if (grant_fire) begin
                            state_q <= GRANT;
                        end else if (byte_ok) begin
                            byte_q      <= byte_q + 4'd1;
                            addr_q      <= addr_q + 7'd1;
                            req_valid_q <= 1'b1;
                            state_q     <= FETCH;
                        end else if (is_last_entry) begin
                            state_q <= DENY;
                        end else begin
                            entry_q     <= entry_q + 1'b1;
                            byte_q      <= '0;
                            addr_q      <= next_entry_addr;
                            req_valid_q <= 1'b1;
                            state_q     <= FETCH;
                        end
                    end
                end
                GRANT, DENY: state_q <= IDLE;
                default:     state_q <= IDLE;
            endcase

            if (grant_fire) begin
                fail_q <= '0;
            end else if (deny_fire && !lockout_q) begin
                fail_q <= lock_trip ? '0 : fail_q + 1'b1;
            end

            if (lock_trip) begin
                lockout_q    <= (LOCKOUT_CYCLES != 0);
                lock_timer_q <= LW'(LOCKOUT_CYCLES);
            end else if (lock_timer_q != '0) begin
                lock_timer_q <= lock_timer_q - 1'b1;
                lockout_q    <= (lock_timer_q != LW'(1));
            end
        end
    end

    // Independent per-door timers; a re-grant reloads the full open time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NUM_DOORS; d++) door_timer_q[d] <= '0;
            unlock_q <= '0;
        end else begin
            for (int d = 0; d < NUM_DOORS; d++) begin
                if (grant_fire && (sel_q == DSEL_W'(d))) begin
                    door_timer_q[d] <= UW'(UNLOCK_CYCLES);
                    unlock_q[d]     <= 1'b1;
                end else if (door_timer_q[d] != '0) begin
                    door_timer_q[d] <= door_timer_q[d] - 1'b1;
                    unlock_q[d]     <= (door_timer_q[d] != UW'(1));
                end
            end
        end
    end

    assign ee_req_valid_o   = req_valid_q;
    assign ee_req_addr_o    = addr_q;
    assign door_unlock_o    = unlock_q;
    assign status_granted_o = granted_q;
    assign status_denied_o  = denied_q;
    assign lockout_o        = lockout_q;
    assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_access_guard_ctrl.sv
// Randomised bench for access_guard_ctrl: an allowlist model predicts every EEPROM read,
// the grant/deny decision and the door/lockout windows cycle by cycle.
module tb_access_guard_ctrl;

    localparam int         NUM_DOORS      = 2;
    localparam int         ID_BYTES       = 4;
    localparam int         NUM_ENTRIES    = 8;
    localparam logic [6:0] BASE_ADDR      = 7'h7E;
    localparam int         UNLOCK_CYCLES  = 20;
    localparam int         MAX_FAILS      = 3;
    localparam int         LOCKOUT_CYCLES = 50;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        authSuccess = 1'b0;
    logic        authFailed = 1'b0;
    logic [31:0] cardId = '0;
    logic        doorSel = 1'b0;
    logic        eeReqValid;
    logic        eeReqReady = 1'b0;
    logic [6:0]  eeReqAddr;
    logic        eeRspValid = 1'b0;
    logic [7:0]  eeRspData = '0;
    logic [1:0]  doorUnlock;
    logic        statusGranted;
    logic        statusDenied;
    logic        lockout;
    logic        busy;

    access_guard_ctrl #(
        .NUM_DOORS(NUM_DOORS), .ID_BYTES(ID_BYTES), .NUM_ENTRIES(NUM_ENTRIES),
        .BASE_ADDR(BASE_ADDR), .UNLOCK_CYCLES(UNLOCK_CYCLES), .MAX_FAILS(MAX_FAILS),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rstN),
        .auth_success_i(authSuccess), .auth_failed_i(authFailed),
        .card_id_i(cardId), .door_sel_i(doorSel),
        .ee_req_valid_o(eeReqValid), .ee_req_ready_i(eeReqReady), .ee_req_addr_o(eeReqAddr),
        .ee_rsp_valid_i(eeRspValid), .ee_rsp_data_i(eeRspData),
        .door_unlock_o(doorUnlock), .status_granted_o(statusGranted),
        .status_denied_o(statusDenied), .lockout_o(lockout), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [128];
    int expReads [$];
    int doorUntil [NUM_DOORS];
    int lockUntil = 0;
    int fails = 0;
    int expGrantCyc = -1;
    int expDenyCyc = -1;
    int busyStart = -1;
    int busyEnd = -1;
    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and compare every continuously-predicted output.
    task automatic waitCycle();
        @(negedge clk);
        for (int d = 0; d < NUM_DOORS; d++)
            checkOutput($sformatf("door%0d", d), 32'(doorUnlock[d]), 32'(cyc < doorUntil[d]));
        checkOutput("lockout", 32'(lockout), 32'(cyc < lockUntil));
        checkOutput("granted", 32'(statusGranted), 32'(cyc == expGrantCyc));
        checkOutput("denied", 32'(statusDenied), 32'(cyc == expDenyCyc));
        checkOutput("busy", 32'(busy), 32'((cyc >= busyStart) && (cyc <= busyEnd)));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "ReqValid"}, 32'(eeReqValid), 32'd0);
        checkOutput({tag, "ReqAddr"}, 32'(eeReqAddr), 32'd0);
        checkOutput({tag, "Doors"}, 32'(doorUnlock), 32'd0);
        checkOutput({tag, "Granted"}, 32'(statusGranted), 32'd0);
        checkOutput({tag, "Denied"}, 32'(statusDenied), 32'd0);
        checkOutput({tag, "Lockout"}, 32'(lockout), 32'd0);
        checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
    endtask

    task automatic resetModel();
        for (int d = 0; d < NUM_DOORS; d++) doorUntil[d] = 0;
        lockUntil = 0;
        fails = 0;
        expGrantCyc = -1;
        expDenyCyc = -1;
        busyStart = -1;
        busyEnd = -1;
    endtask

    // Allowlist walk: list of byte addresses read and whether some entry grants.
    function automatic bit lookupModel(input logic [31:0] id, input int sel);
        expReads.delete();
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            int base = (int'(BASE_ADDR) + e * (ID_BYTES + 1)) % 128;
            bit hit = 1'b1;
            expReads.push_back(base);
            if (sel >= NUM_DOORS || ((mem[base] >> sel) & 8'h01) == 8'h00) continue;
            for (int b = 1; b <= ID_BYTES; b++) begin
                int a = (base + b) % 128;
                logic [7:0] want = 8'(id >> (8 * (ID_BYTES - b)));
                expReads.push_back(a);
                if (mem[a] != want) begin
                    hit = 1'b0;
                    break;
                end
            end
            if (hit) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic noteGrant(input int sel, input int k);
        expGrantCyc = k;
        doorUntil[sel] = k + UNLOCK_CYCLES;
        fails = 0;
    endtask

    task automatic noteDeny(input bit locked, input int k);
        expDenyCyc = k;
        if (!locked) begin
            fails++;
            if (fails == MAX_FAILS) begin
                lockUntil = k + LOCKOUT_CYCLES;
                fails = 0;
            end
        end
    endtask

    // One authentication event; stall/lat < 0 pick random values, abortAt >= 0 resets in that read's WAIT.
    task automatic applyStimulus(input bit succ, input bit fail, input logic [31:0] id, input int sel,
                                 input int stall, input int lat, input bit dropPulse, input int abortAt);
        bit grant;
        bit locked;
        int nStall;
        int nLat;
        grant = lookupModel(id, sel);
        locked = (cyc < lockUntil);
        authSuccess = succ;
        authFailed = fail;
        cardId = id;
        doorSel = 1'(sel);
        if (fail || locked) begin
            busyStart = cyc + 1;
            busyEnd = cyc + 1;
            noteDeny(locked, cyc + 1);
            waitCycle();
            authSuccess = 1'b0;
            authFailed = 1'b0;
            checkOutput("noReqOnDeny", 32'(eeReqValid), 32'd0);
            waitCycle();
            checkOutput("noReqAfterDeny", 32'(eeReqValid), 32'd0);
            return;
        end
        busyStart = cyc + 1;
        busyEnd = 32'h3FFF_FFFF;
        waitCycle();
        authSuccess = 1'b0;
        for (int i = 0; i < expReads.size(); i++) begin
            nStall = (stall >= 0) ? stall : int'($urandom_range(0, 2));
            nLat = (lat >= 1) ? lat : int'($urandom_range(1, 3));
            checkOutput("reqValid", 32'(eeReqValid), 32'd1);
            checkOutput($sformatf("reqAddr%0d", i), 32'(eeReqAddr), 32'(expReads[i]));
            for (int s = 0; s < nStall; s++) begin
                eeRspValid = 1'($urandom_range(0, 1));
                eeRspData = 8'($urandom);
                waitCycle();
                checkOutput("stallValid", 32'(eeReqValid), 32'd1);
                checkOutput("stallAddr", 32'(eeReqAddr), 32'(expReads[i]));
            end
            eeRspValid = 1'b0;
            eeReqReady = 1'b1;
            waitCycle();
            eeReqReady = 1'b0;
            checkOutput("reqDropped", 32'(eeReqValid), 32'd0);
            if (i == abortAt) begin
                rstN = 1'b0;
                #1;
                checkAllZero("abort");
                resetModel();
                waitCycle();
                waitCycle();
                rstN = 1'b1;
                waitCycle();
                return;
            end
            if (dropPulse && i == 0) authFailed = 1'b1;
            for (int w = 1; w < nLat; w++) waitCycle();
            eeRspValid = 1'b1;
            eeRspData = mem[expReads[i]];
            if (i == expReads.size() - 1) begin
                busyEnd = cyc + 1;
                if (grant) noteGrant(sel, cyc + 1);
                else noteDeny(1'b0, cyc + 1);
            end
            waitCycle();
            eeRspValid = 1'b0;
            eeRspData = 8'($urandom);
            authFailed = 1'b0;
        end
        checkOutput("reqIdleAtDecision", 32'(eeReqValid), 32'd0);
        waitCycle();
    endtask

    task automatic loadEntry(input int e, input logic [7:0] mask, input logic [31:0] id);
        int base = (int'(BASE_ADDR) + e * (ID_BYTES + 1)) % 128;
        mem[base] = mask;
        for (int b = 1; b <= ID_BYTES; b++) mem[(base + b) % 128] = 8'(id >> (8 * (ID_BYTES - b)));
    endtask

    initial begin
        logic [31:0] rid;
        int pick;
        int r;
        for (int a = 0; a < 128; a++) mem[a] = 8'($urandom);
        for (int d = 0; d < NUM_DOORS; d++) doorUntil[d] = 0;
        loadEntry(0, 8'h01, 32'hDEADBEEF);
        loadEntry(1, 8'h02, 32'hCAFEF00D);
        loadEntry(2, 8'h03, 32'hDEADBE00);
        loadEntry(3, 8'h03, 32'h12345678);
        for (int e = 4; e < NUM_ENTRIES; e++) loadEntry(e, 8'($urandom_range(0, 3)), $urandom);

        waitCycle();
        checkAllZero("reset");
        waitCycle();
        rstN = 1'b1;
        waitCycle();

        // Wrapped entry-0 grant, then the mask-skip walk for door 1.
        applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 0, 0, -1, 1'b0, -1);
        repeat (24) waitCycle();
        applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 1, -1, -1, 1'b0, -1);
        applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 0, -1, -1, 1'b0, -1);
        applyStimulus(1'b0, 1'b1, 32'h0, 0, -1, -1, 1'b0, -1);
        applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 0, -1, -1, 1'b0, -1);
        repeat (LOCKOUT_CYCLES) waitCycle();
        applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 0, -1, -1, 1'b0, -1);
        repeat (25) waitCycle();

        // Door-0 reload with five cycles left, then door 1 overlapping.
        applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 0, 0, 1, 1'b0, -1);
        repeat (3) waitCycle();
        applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 0, 0, 1, 1'b0, -1);
        applyStimulus(1'b1, 1'b0, 32'hCAFEF00D, 1, 0, 1, 1'b0, -1);
        repeat (25) waitCycle();

        applyStimulus(1'b1, 1'b0, 32'h12345678, 1, 7, -1, 1'b1, -1);
        repeat (2) waitCycle();

        for (int t = 0; t < 30; t++) begin
            pick = int'($urandom_range(0, 5));
            case (pick)
                0: rid = 32'hDEADBEEF;
                1: rid = 32'hCAFEF00D;
                2: rid = 32'h12345678;
                3: rid = 32'hDEADBE00;
                default: rid = $urandom;
            endcase
            r = int'($urandom_range(0, 9));
            applyStimulus(1'b1, r < 2, rid, int'($urandom_range(0, 1)), -1, -1, r == 9, -1);
            repeat ($urandom_range(0, 4)) waitCycle();
        end

        repeat (LOCKOUT_CYCLES + 5) waitCycle();
        applyStimulus(1'b1, 1'b0, 32'hCAFEF00D, 1, 0, 1, 1'b0, -1);
        applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 0, 0, 2, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 0, -1, -1, 1'b0, -1);
        repeat (UNLOCK_CYCLES + 2) waitCycle();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
